// File: rtl/click_counter_arbiter.sv
// Round-robin arbiter that collects results from N click-counter channels and
// presents one {id, count} word at a time on a valid/ready output stream.
module click_counter_arbiter #(
  parameter int N_CH    = 8,
  parameter int COUNT_W = 24,
  parameter int ID_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ch_ready,
  input  logic [N_CH*COUNT_W-1:0] ch_count,
  input  logic [N_CH*ID_W-1:0]    ch_id,
  output logic [N_CH-1:0]         ch_ack,
  input  logic [N_CH-1:0]         ch_mask,
  output logic [ID_W+COUNT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clear_stats,
  output logic [31:0]             results_cnt
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IDX_W = PTR_W + 1;

  localparam logic [0:0] ST_ARB = 1'b0;
  localparam logic [0:0] ST_ACK = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [N_CH-1:0]  elig;
  logic [IDX_W-1:0] idx_w;
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] ptr_next;
  logic             slot_free;
  logic             accept;

  function automatic logic [N_CH-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign elig      = ch_ready & ch_mask;
  assign accept    = out_valid & out_ready;
  assign slot_free = ~out_valid | out_ready;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_w       = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx_w = {1'b0, ptr} + IDX_W'(k);
      if (idx_w >= IDX_W'(N_CH)) begin
        idx_w = idx_w - IDX_W'(N_CH);
      end
      if (elig[idx_w[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_w[PTR_W-1:0];
      end
    end
  end

  assign ptr_next = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      ptr       <= '0;
      ch_ack    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_ARB: begin
          if (grant_found && slot_free) begin
            out_data  <= {ch_id[grant_idx*ID_W +: ID_W], ch_count[grant_idx*COUNT_W +: COUNT_W]};
            out_valid <= 1'b1;
            ch_ack    <= onehot(grant_idx);
            ptr       <= ptr_next;
            state     <= ST_ACK;
          end
        end
        // One-cycle ack; no arbitration so the acked channel's stale ready is skipped.
        default: begin
          ch_ack <= '0;
          state  <= ST_ARB;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      results_cnt <= '0;
    end else if (accept) begin
      results_cnt <= results_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_click_counter_arbiter.sv
// Bench for click_counter_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a round-robin reference model.
module tb_click_counter_arbiter;

  localparam int N  = 8;
  localparam int CW = 24;
  localparam int IW = 8;
  localparam int W  = IW + CW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_ready;
  logic [N*CW-1:0] ch_count;
  logic [N*IW-1:0] ch_id;
  logic [N-1:0]    ch_ack;
  logic [N-1:0]    ch_mask;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic            clear_stats;
  logic [31:0]     results_cnt;

  logic [N-1:0]    hold;
  bit              chk_en;
  int              n_checks;
  int              n_fail;

  int              m_ptr;
  bit              m_busy;
  bit              m_valid;
  logic [W-1:0]    m_data;
  logic [N-1:0]    m_ack;
  logic [31:0]     m_cnt;

  always #5 clk = ~clk;

  click_counter_arbiter #(.N_CH(N), .COUNT_W(CW), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_ready    (ch_ready),
    .ch_count    (ch_count),
    .ch_id       (ch_id),
    .ch_ack      (ch_ack),
    .ch_mask     (ch_mask),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear_stats (clear_stats),
    .results_cnt (results_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_grant();
    int c;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (ch_ready[c] && ch_mask[c]) return c;
    end
    return -1;
  endfunction

  // Reference: a grant happens whenever the output slot is free, eligible work
  // exists, and the previous cycle was not itself a grant.
  task automatic model_update();
    bit acc;
    int g;
    if (rst) begin
      m_ptr = 0; m_busy = 0; m_valid = 0; m_data = '0; m_ack = '0; m_cnt = '0;
      return;
    end
    acc = m_valid && out_ready;
    if (clear_stats) m_cnt = '0;
    else if (acc) m_cnt = m_cnt + 32'd1;
    if (acc) m_valid = 0;
    m_ack = '0;
    if (m_busy) begin
      m_busy = 0;
    end else if (!m_valid) begin
      g = pick_grant();
      if (g >= 0) begin
        m_data   = {ch_id[g*IW +: IW], ch_count[g*CW +: CW]};
        m_valid  = 1;
        m_ack[g] = 1'b1;
        m_ptr    = (g + 1) % N;
        m_busy   = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (chk_en) begin
      check("model_ack", ch_ack, m_ack);
      check("model_valid", out_valid, m_valid);
      check("model_data", out_data, m_data);
      check("model_cnt", results_cnt, m_cnt);
    end
    for (int i = 0; i < N; i++) begin
      if (ch_ack[i] && !hold[i]) ch_ready[i] = 1'b0;
    end
  endtask

  task automatic wait_ack(input string name, input logic [N-1:0] exp, input int max, output int n);
    step();
    n = 1;
    while (ch_ack == '0 && n < max) begin
      step();
      n++;
    end
    check(name, ch_ack, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_ready = '0; hold = '0; clear_stats = 1'b0; out_ready = 1'b1; ch_mask = '1;
    step();
    step();
    rst = 1'b0;
  endtask

  int           n;
  int           acks;
  int           bad;
  logic [W-1:0] exp_w;

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 0;
    m_ptr = 0; m_busy = 0; m_valid = 0; m_data = '0; m_ack = '0; m_cnt = '0;
    for (int i = 0; i < N; i++) begin
      ch_count[i*CW +: CW] = CW'($urandom);
      ch_id[i*IW +: IW]    = IW'($urandom);
    end
    do_reset();
    chk_en = 1;

    // Reset values and a single-channel transaction
    check("rst_ack", ch_ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_cnt", results_cnt, 0);
    ch_count[3*CW +: CW] = 24'h00012C;
    ch_id[3*IW +: IW]    = 8'h05;
    ch_ready[3]          = 1'b1;
    wait_ack("t1_ack", 8'h08, 4, n);
    check("t1_latency", n, 1);
    check("t1_data", out_data, 32'h0500012C);
    check("t1_valid", out_valid, 1);
    step();
    check("t1_ack_clear", ch_ack, 0);
    check("t1_cnt", results_cnt, 1);

    // Three simultaneous requests from ptr=0, then ptr back at 0
    do_reset();
    ch_ready = 8'h83;
    wait_ack("t2_g0", 8'h01, 4, n);
    wait_ack("t2_g1", 8'h02, 4, n);
    check("t2_gap1", n, 2);
    wait_ack("t2_g7", 8'h80, 4, n);
    check("t2_gap7", n, 2);
    ch_ready = 8'h03;
    wait_ack("t2_ptr0", 8'h01, 4, n);
    wait_ack("t2_ptr0_next", 8'h02, 4, n);
    step();
    step();
    check("t2_cnt", results_cnt, 5);

    // Wrap: ptr=6 with ch2 and ch6 ready
    do_reset();
    ch_ready = 8'h20;
    wait_ack("t3_g5", 8'h20, 4, n);
    step();
    ch_ready = 8'h44;
    wait_ack("t3_g6", 8'h40, 4, n);
    wait_ack("t3_g2", 8'h04, 4, n);
    step();

    // Backpressure with ch1 holding ready
    do_reset();
    out_ready   = 1'b0;
    hold[1]     = 1'b1;
    ch_ready[1] = 1'b1;
    exp_w = {ch_id[IW +: IW], ch_count[CW +: CW]};
    wait_ack("t4_ack", 8'h02, 4, n);
    ch_count[CW +: CW] = ch_count[CW +: CW] ^ 24'hFFFFFF;
    acks = 0;
    bad  = 0;
    repeat (20) begin
      step();
      if (ch_ack != '0) acks++;
      if (out_data !== exp_w) bad++;
    end
    check("t4_unstable_cycles", bad, 0);
    check("t4_extra_acks", acks, 0);
    check("t4_valid_held", out_valid, 1);
    out_ready = 1'b1;
    exp_w = {ch_id[IW +: IW], ch_count[CW +: CW]};
    wait_ack("t4_regrant", 8'h02, 4, n);
    check("t4_no_bubble", n, 1);
    check("t4_cnt", results_cnt, 1);
    check("t4_new_data", out_data, exp_w);
    hold = '0;
    ch_ready = '0;
    step();
    step();

    // Mask blocks ch0 until the bit is set
    do_reset();
    ch_mask     = 8'hFE;
    ch_ready[0] = 1'b1;
    acks = 0;
    repeat (6) begin
      step();
      if (ch_ack != '0 || out_valid) acks++;
    end
    check("t5_masked_activity", acks, 0);
    ch_mask = '1;
    wait_ack("t5_unmask", 8'h01, 3, n);
    check("t5_latency", n, 1);
    step();
    step();
    check("t5_cnt", results_cnt, 1);

    // Reset during ACK with a stalled word; ptr must return to 0
    out_ready = 1'b0;
    hold      = 8'h24;
    ch_ready  = 8'h24;
    wait_ack("t6_first", 8'h04, 4, n);
    check("t6_valid_before", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_ack", ch_ack, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_cnt", results_cnt, 0);
    wait_ack("t6_regrant", 8'h04, 4, n);
    check("t6_latency", n, 1);
    hold      = '0;
    ch_ready  = '0;
    out_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      clear_stats = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0) ch_mask = N'($urandom | $urandom);
      for (int i = 0; i < N; i++) begin
        if (!ch_ready[i] && $urandom_range(0, 3) == 0) begin
          ch_ready[i]          = 1'b1;
          ch_count[i*CW +: CW] = CW'($urandom);
          ch_id[i*IW +: IW]    = IW'($urandom);
        end
        hold[i] = ($urandom_range(0, 9) == 0);
      end
      step();
    end
    rst = 1'b0; clear_stats = 1'b0; ch_ready = '0; hold = '0; out_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
